// File: rtl/psum_accumulator.sv
// Column partial-sum accumulator: splits each accepted psum beat into 1, 2 or 4 lanes
// according to the latched precision mode and accumulates them into four ACC_WIDTH lanes.
module psum_accumulator #(
    parameter int COL_WIDTH = 13,
    parameter int ACC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             acc_len,
    input  logic [3:0]             weight_width,
    input  logic                   s_signed,
    input  logic [COL_WIDTH*4-1:0] psum_in,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    output logic                   busy,
    output logic [ACC_WIDTH*4-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Handshakes: a beat moves when psum_valid && psum_ready, a result moves when
    // out_valid && out_ready; valid never waits on ready, and busy mirrors state ACCUM.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_2B = 2'd0,
        MODE_4B = 2'd1,
        MODE_8B = 2'd2
    } mode_t;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    logic                   sgn_q, sgn_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q [4];
    logic [ACC_WIDTH-1:0]   acc_d [4];
    logic [ACC_WIDTH*4-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    mode_t                  mode_new;
    logic                   ww_legal;
    logic                   start_ok;
    logic                   is_final;
    logic                   beat_acc;
    logic [ACC_WIDTH-1:0]   l8;
    logic [ACC_WIDTH-1:0]   l4 [2];
    logic [ACC_WIDTH-1:0]   l2 [4];
    logic [ACC_WIDTH-1:0]   lane [4];
    logic [ACC_WIDTH-1:0]   sum [4];

    always_comb begin
        ww_legal = 1'b1;
        mode_new = MODE_2B;
        if (weight_width == 4'b1000) begin
            mode_new = MODE_8B;
        end else if (weight_width == 4'b0100) begin
            mode_new = MODE_4B;
        end else if (weight_width[3:2] == 2'b00) begin
            mode_new = MODE_2B;
        end else begin
            ww_legal = 1'b0;
        end
    end

    assign start_ok   = start && (acc_len != 8'd0) && ww_legal;
    assign is_final   = (cnt_q == len_q - 8'd1);
    // A final beat would overwrite the result register, so it waits while the output is stuck.
    assign psum_ready = !rst && (state_q == ACCUM) && !(is_final && out_valid_q && !out_ready);
    assign busy       = !rst && (state_q == ACCUM);
    assign beat_acc   = psum_valid && psum_ready;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

    // Lanes at least as wide as the accumulator only need truncation; narrower ones extend.
    generate
        if (4*COL_WIDTH >= ACC_WIDTH) begin : g_l8_trunc
            assign l8 = psum_in[ACC_WIDTH-1:0];
        end else begin : g_l8_ext
            assign l8 = sgn_q ? ACC_WIDTH'($signed(psum_in)) : ACC_WIDTH'(psum_in);
        end

        for (genvar g = 0; g < 2; g++) begin : g_l4
            logic [2*COL_WIDTH-1:0] raw;
            assign raw = psum_in[2*COL_WIDTH*g +: 2*COL_WIDTH];
            if (2*COL_WIDTH >= ACC_WIDTH) begin : g_trunc
                assign l4[g] = raw[ACC_WIDTH-1:0];
            end else begin : g_ext
                assign l4[g] = sgn_q ? ACC_WIDTH'($signed(raw)) : ACC_WIDTH'(raw);
            end
        end

        for (genvar g = 0; g < 4; g++) begin : g_l2
            logic [COL_WIDTH-1:0] raw;
            assign raw = psum_in[COL_WIDTH*g +: COL_WIDTH];
            if (COL_WIDTH >= ACC_WIDTH) begin : g_trunc
                assign l2[g] = raw[ACC_WIDTH-1:0];
            end else begin : g_ext
                assign l2[g] = sgn_q ? ACC_WIDTH'($signed(raw)) : ACC_WIDTH'(raw);
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = '0;
        end
        case (mode_q)
            MODE_8B: begin
                lane[0] = l8;
            end
            MODE_4B: begin
                lane[0] = l4[0];
                lane[1] = l4[1];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    lane[i] = l2[i];
                end
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            sum[i] = acc_q[i] + lane[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sgn_d       = sgn_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mode_d  = mode_new;
                    sgn_d   = s_signed;
                    len_d   = acc_len;
                    cnt_d   = 8'd0;
                    state_d = ACCUM;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = '0;
                    end
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + 8'd1;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = sum[i];
                    end
                    if (is_final) begin
                        for (int i = 0; i < 4; i++) begin
                            out_data_d[ACC_WIDTH*i +: ACC_WIDTH] = sum[i];
                        end
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_2B;
            sgn_q       <= 1'b0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sgn_q       <= sgn_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data));
    a_idle_not_ready: assert property (@(posedge clk)
        (state_q == IDLE) |-> !psum_ready);

endmodule
